// File: rtl/jimmy_boot_ctrl_pkg.sv
// Shared types for the jimmy boot loader: FSM states, output flag bundle, fill byte.
// Outputs are decoded from the next state, so every flag is registered with the state.
package jimmy_boot_pkg;

    typedef enum logic [2:0] {
        IDLE, LOAD_LEN, LOAD_DATA, CHECK, CLEAR, HOLD, RUN, ERROR
    } boot_state_t;

    localparam logic [7:0] NOP_BYTE       = 8'h70;
    localparam logic [8:0] LEN_ZERO_MEANS = 9'd256;

    typedef struct packed {
        logic rx_ready;
        logic cpu_reset;
        logic busy;
        logic done;
        logic err;
    } stat_t;

    function automatic stat_t state_flags(input boot_state_t s);
        stat_t f;
        f = '0;
        case (s)
            LOAD_LEN, LOAD_DATA, CHECK: begin
                f.rx_ready = 1'b1;
                f.busy     = 1'b1;
            end
            CLEAR, HOLD: f.busy = 1'b1;
            RUN: begin
                f.cpu_reset = 1'b1;
                f.done      = 1'b1;
            end
            ERROR:   f.err = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/jimmy_boot_ctrl_if.sv
// Image byte stream (valid/ready) plus program-memory write port of the boot loader.
// slave = loader side, master = byte source / memory side.
interface jimmy_boot_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       pm_we;
    logic [7:0] pm_addr;
    logic [7:0] pm_wdata;

    modport master (output rx_data, rx_valid, input rx_ready, pm_we, pm_addr, pm_wdata);
    modport slave  (input rx_data, rx_valid, output rx_ready, pm_we, pm_addr, pm_wdata);
endinterface

// File: rtl/jimmy_boot_ctrl_hold_cnt.sv
// Loadable down-counter for the CPU reset hold; last is high while the count sits at 1.
// Load has priority over decrement; the count parks at zero.
module jimmy_boot_hold_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             last
);
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign last = (cnt == WIDTH'(1));
endmodule

// File: rtl/jimmy_boot_ctrl.sv
// Boot loader: LEN/data/CHK byte stream into program memory, CPU held in reset until verified + hold.
// One cycle byte->pm_we; rx_ready only in LOAD_LEN/LOAD_DATA/CHECK. JIMMY_BOOT_CLEAR_EN adds NOP fill of unloaded space.
module jimmy_boot_ctrl
    import jimmy_boot_pkg::*;
#(
    parameter int RESET_HOLD = 4,
    parameter bit AUTO_BOOT  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               boot_req,
    jimmy_boot_ctrl_if.slave   bus,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [8:0]         byte_count
);
    boot_state_t state, nxt;
    stat_t       nxt_flags;
    logic [8:0]  len;
    logic [7:0]  sum;
    logic [7:0]  chk_sum;
    logic        xfer;
    logic        hold_last;

    assign xfer      = bus.rx_valid & bus.rx_ready;
    assign chk_sum   = sum + bus.rx_data;
    assign nxt_flags = state_flags(nxt);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (boot_req || AUTO_BOOT) nxt = LOAD_LEN;
            LOAD_LEN:  if (xfer) nxt = LOAD_DATA;
            LOAD_DATA: if (xfer && ((byte_count + 9'd1) == len)) nxt = CHECK;
            CHECK: begin
                if (xfer) begin
                    if (chk_sum == 8'h00) begin
`ifdef JIMMY_BOOT_CLEAR_EN
                        nxt = (len == LEN_ZERO_MEANS) ? HOLD : CLEAR;
`else
                        nxt = HOLD;
`endif
                    end else begin
                        nxt = ERROR;
                    end
                end
            end
            CLEAR:      if (bus.pm_addr == 8'hFF) nxt = HOLD;
            HOLD:       if (hold_last) nxt = RUN;
            RUN, ERROR: if (boot_req) nxt = LOAD_LEN;
            default:    nxt = IDLE;
        endcase
    end

    jimmy_boot_hold_cnt #(.WIDTH(8)) u_hold_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     ((nxt == HOLD) && (state != HOLD)),
        .load_val (8'(RESET_HOLD)),
        .dec      (state == HOLD),
        .last     (hold_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bus.rx_ready <= 1'b0;
            bus.pm_we    <= 1'b0;
            bus.pm_addr  <= 8'h00;
            bus.pm_wdata <= 8'h00;
            cpu_reset    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            byte_count   <= 9'd0;
            len          <= 9'd0;
            sum          <= 8'h00;
        end else begin
            state        <= nxt;
            bus.rx_ready <= nxt_flags.rx_ready;
            cpu_reset    <= nxt_flags.cpu_reset;
            busy         <= nxt_flags.busy;
            done         <= nxt_flags.done;
            err          <= nxt_flags.err;
            bus.pm_we    <= 1'b0;
            case (state)
                LOAD_LEN: begin
                    if (xfer) begin
                        len         <= (bus.rx_data == 8'h00) ? LEN_ZERO_MEANS : {1'b0, bus.rx_data};
                        sum         <= 8'h00;
                        byte_count  <= 9'd0;
                        bus.pm_addr <= 8'h00;
                    end
                end
                LOAD_DATA: begin
                    if (xfer) begin
                        bus.pm_we    <= 1'b1;
                        bus.pm_wdata <= bus.rx_data;
                        bus.pm_addr  <= byte_count[7:0];
                        sum          <= chk_sum;
                        byte_count   <= byte_count + 9'd1;
                    end
                end
                default: ;
            endcase
`ifdef JIMMY_BOOT_CLEAR_EN
            // Fill starts at the first unloaded address and walks up to 255.
            if (nxt == CLEAR) begin
                bus.pm_we    <= 1'b1;
                bus.pm_wdata <= NOP_BYTE;
                bus.pm_addr  <= (state == CLEAR) ? (bus.pm_addr + 8'd1) : len[7:0];
            end
`endif
        end
    end
endmodule

// File: tb/tb_jimmy_boot_ctrl.sv
// Bench for jimmy_boot_ctrl: transaction-level model of the image protocol checked every cycle,
// directed images from the test plan, then randomized images with random gaps and stray boot_req.
module tb_jimmy_boot_ctrl;
    localparam int HOLD = 4;
`ifdef JIMMY_BOOT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef enum int {M_IDLE, M_LOAD, M_WAIT, M_RUN, M_ERR} mode_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       boot_req = 1'b0;
    logic       cpu_reset, busy, done, err;
    logic [8:0] byte_count;

    jimmy_boot_ctrl_if bus();

    jimmy_boot_ctrl #(.RESET_HOLD(HOLD), .AUTO_BOOT(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .boot_req   (boot_req),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: protocol phase, load progress and the remaining busy time after a good CHK.
    mode_t      mode = M_IDLE;
    int         phase, m_len, m_cnt, m_sum, m_bc, rem, clr_next, exp_addr, exp_dat;
    bit         exp_we;
    logic [7:0] tb_mem[256];
    int         exp_mem[256];

    task automatic model_step();
        bit xfer;
        int b;
        xfer = bus.rx_valid && bus.rx_ready;
        b    = int'(bus.rx_data);
        exp_we = 1'b0;
        case (mode)
            M_IDLE: begin mode = M_LOAD; phase = 0; end
            M_LOAD: if (xfer) begin
                if (phase == 0) begin
                    m_len = (b == 0) ? 256 : b;
                    m_cnt = 0; m_sum = 0; m_bc = 0; phase = 1;
                end else if (phase == 1) begin
                    exp_we = 1'b1; exp_addr = m_cnt % 256; exp_dat = b; exp_mem[exp_addr] = b;
                    m_sum += b; m_cnt++; m_bc = m_cnt;
                    if (m_cnt == m_len) phase = 2;
                end else if ((m_sum + b) % 256 == 0) begin
                    mode = M_WAIT; rem = HOLD; clr_next = 256;
                    if (CLR && m_len < 256) begin
                        rem += 256 - m_len;
                        exp_we = 1'b1; exp_addr = m_len; exp_dat = 'h70; exp_mem[m_len] = 'h70;
                        clr_next = m_len + 1;
                    end
                end else begin
                    mode = M_ERR;
                end
            end
            M_WAIT: begin
                if (clr_next < 256) begin
                    exp_we = 1'b1; exp_addr = clr_next; exp_dat = 'h70; exp_mem[clr_next] = 'h70;
                    clr_next++;
                end
                rem--;
                if (rem == 0) mode = M_RUN;
            end
            default: if (boot_req) begin mode = M_LOAD; phase = 0; end
        endcase
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mode = M_IDLE; m_bc = 0; exp_we = 1'b0;
        end
        chk("rx_ready", int'(bus.rx_ready), int'(mode == M_LOAD));
        chk("busy", int'(busy), int'(mode == M_LOAD || mode == M_WAIT));
        chk("done", int'(done), int'(mode == M_RUN));
        chk("cpu_reset", int'(cpu_reset), int'(mode == M_RUN));
        chk("err", int'(err), int'(mode == M_ERR));
        chk("byte_count", int'(byte_count), m_bc);
        chk("pm_we", int'(bus.pm_we), int'(exp_we));
        if (exp_we) begin
            chk("pm_addr", int'(bus.pm_addr), exp_addr);
            chk("pm_wdata", int'(bus.pm_wdata), exp_dat);
        end
        if (mode == M_IDLE) begin
            chk("idle_pm_addr", int'(bus.pm_addr), 0);
            chk("idle_pm_wdata", int'(bus.pm_wdata), 0);
        end
        if (bus.pm_we) tb_mem[bus.pm_addr] = bus.pm_wdata;
        if (reset) model_step();
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        bit ok;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int i = 0; i < g; i++) begin
            bus.rx_valid = 1'b0;
            boot_req = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end
        boot_req = 1'b0;
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            ok = bus.rx_ready;
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL send_byte: rx_ready never seen, expected acceptance within 1000 cycles");
        end
    endtask

    task automatic send_image(input int lb, input bq_t d, input int ck, input int gap);
        send_byte(8'(lb), gap);
        foreach (d[i]) send_byte(d[i], gap);
        send_byte(8'(ck), gap);
    endtask

    task automatic wait_end(output int hc);
        bit ok;
        hc = 0; ok = 1'b0;
        for (int g = 0; g < 2000 && !ok; g++) begin
            @(negedge clk);
            if (done || err) ok = 1'b1;
            else if (busy && !bus.rx_ready) hc++;
        end
        @(posedge clk); #1;
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL wait_end: neither done nor err, expected one within 2000 cycles");
        end
    endtask

    task automatic pulse_req();
        boot_req = 1'b1;
        @(posedge clk); #1;
        boot_req = 1'b0;
    endtask

    initial begin
        bq_t q;
        int  hc, ln, s, ck;
        for (int i = 0; i < 256; i++) begin tb_mem[i] = 8'h00; exp_mem[i] = 0; end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk); #1;
        chk("rst_rx_ready", int'(bus.rx_ready), 0);
        chk("rst_pm_we", int'(bus.pm_we), 0);
        chk("rst_pm_addr", int'(bus.pm_addr), 0);
        chk("rst_cpu_reset", int'(cpu_reset), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_byte_count", int'(byte_count), 0);
        reset = 1'b1;

        // Good 3-byte image with auto boot.
        q = '{8'h80, 8'h05, 8'hA4};
        send_image(3, q, 'hD7, 0);
        wait_end(hc);
`ifdef JIMMY_BOOT_CLEAR_EN
        chk("t1_hold_cycles", hc, 257);
`else
        chk("t1_hold_cycles", hc, 4);
`endif
        chk("t1_done", int'(done), 1);
        chk("t1_cpu_reset", int'(cpu_reset), 1);
        chk("t1_byte_count", int'(byte_count), 3);
        chk("t1_mem0", int'(tb_mem[0]), 'h80);
        chk("t1_mem1", int'(tb_mem[1]), 'h05);
        chk("t1_mem2", int'(tb_mem[2]), 'hA4);

        // Bad checksum, then recovery.
        pulse_req();
        send_image(3, q, 'hD8, 0);
        wait_end(hc);
        chk("t2_err", int'(err), 1);
        chk("t2_cpu_reset", int'(cpu_reset), 0);
        pulse_req();
        send_image(3, q, 'hD7, 1);
        wait_end(hc);
        chk("t2_done", int'(done), 1);
        chk("t2_err_clr", int'(err), 0);

        // LEN=0 means 256 bytes.
        pulse_req();
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'h01);
        send_image(0, q, 'h00, 0);
        wait_end(hc);
        chk("t3_byte_count", int'(byte_count), 256);
        chk("t3_mem255", int'(tb_mem[255]), 'h01);
        chk("t3_done", int'(done), 1);

        // Reset in the middle of a 5-byte load.
        pulse_req();
        send_byte(8'd5, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        reset = 1'b0;
        #1;
        chk("t5_rx_ready", int'(bus.rx_ready), 0);
        chk("t5_pm_we", int'(bus.pm_we), 0);
        chk("t5_pm_addr", int'(bus.pm_addr), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_byte_count", int'(byte_count), 0);
        chk("t5_mem0", int'(tb_mem[0]), 'h11);
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        q = '{8'h0F, 8'hF0, 8'h01};
        send_image(3, q, 'h00, 1);
        wait_end(hc);
        chk("t5_done", int'(done), 1);

        // LEN=2; boot_req held through the fill/hold window, including the RUN edge.
        pulse_req();
        q = '{8'h12, 8'h34};
        send_image(2, q, 'hBA, 0);
        boot_req = 1'b1;
        repeat (HOLD + (CLR ? 254 : 0)) @(posedge clk);
        #1;
        boot_req = 1'b0;
        wait_end(hc);
        chk("t6_done", int'(done), 1);
        chk("t6_byte_count", int'(byte_count), 2);
`ifdef JIMMY_BOOT_CLEAR_EN
        chk("t6_mem255", int'(tb_mem[255]), 'h70);
`else
        chk("t6_mem255", int'(tb_mem[255]), 'h01);
`endif

        // Randomized images.
        for (int k = 0; k < 30; k++) begin
            pulse_req();
            ln = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
            q = {}; s = 0;
            for (int i = 0; i < ((ln == 0) ? 256 : ln); i++) begin
                q.push_back(8'($urandom_range(0, 255)));
                s += int'(q[i]);
            end
            ck = (256 - (s % 256)) % 256;
            if ($urandom_range(0, 3) == 0) ck = (ck + int'($urandom_range(1, 255))) % 256;
            send_image(ln, q, ck, -1);
            wait_end(hc);
        end

        for (int i = 0; i < 256; i++) chk("mem_image", int'(tb_mem[i]), exp_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
